// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state encoding for the BCD-to-binary decoder
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] DADJ_THRESH = 4'd8;
  localparam logic [3:0] DADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - per-digit reverse double-dabble correction (subtract 3 from digits of 8 or more)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  // A digit of 8+ after a right shift carried a ten's half in; remove the 3 it gained.
  always_comb begin
    out_o = in_i;
    if (in_i >= DADJ_THRESH) begin
      out_o = in_i - DADJ_SUB;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential multi-digit BCD to unsigned binary decoder with start/busy/done
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int BW   = 7
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int DW = 4 * NDIG;
  localparam int SW = DW + BW;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_out_q, bin_out_d;
  logic            err_q, err_d;

  logic [SW-1:0]   shifted;
  logic [DW-1:0]   adj_dig;
  logic            bad_digit;

  assign shifted = {dig_q, bin_q} >> 1;

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .in_i  (shifted[BW + 4*g +: 4]),
        .out_o (adj_dig[4*g +: 4])
      );
    end
  endgenerate

  // Flag any incoming digit outside 0..9 so the conversion can be skipped.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Next-state and output logic: capture in IDLE, one shift+correct per CONV cycle, pulse in DONE.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dig_d     = bcd_in;
          bin_d     = '0;
          cnt_d     = '0;
          bin_out_d = '0;
          err_d     = bad_digit;
          state_d   = bad_digit ? ST_DONE : ST_CONV;
        end
      end
      ST_CONV: begin
        busy  = 1'b1;
        dig_d = adj_dig;
        bin_d = shifted[BW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          bin_out_d = shifted[BW-1:0];
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; clr aborts everything back to the idle, zeroed state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      dig_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - self-checking bench for bcd_to_bin (2-digit and 4-digit instances)
module tb_bcd_to_bin;

  logic        clk;
  logic        clr;
  logic        start2, start4;
  logic [7:0]  bcd2;
  logic [15:0] bcd4;
  logic        busy2, done2, err2;
  logic        busy4, done4, err4;
  logic [6:0]  bin2;
  logic [13:0] bin4;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_bin #(.NDIG(2), .BW(7)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
  );

  bcd_to_bin #(.NDIG(4), .BW(14)) dut4 (
    .clk(clk), .clr(clr), .start(start4), .bcd_in(bcd4),
    .busy(busy4), .done(done4), .bin_out(bin4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal meaning of the packed digits; invalid digits give err and value 0.
  function automatic void ref_model(input logic [15:0] b, input int nd, output int v, output bit e);
    int d;
    v = 0;
    e = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) v = 0;
  endfunction

  // Issues one start and observes the handshake; called at a negedge.
  task automatic conv(input bit wide, input logic [15:0] b, output int lat, output int bin,
                      output bit e, output bit busy1, output bit done_after, output int bin_hold);
    int n;
    if (wide) begin start4 = 1'b1; bcd4 = b; end
    else begin start2 = 1'b1; bcd2 = b[7:0]; end
    @(negedge clk);
    n = 1;
    start2 = 1'b0;
    start4 = 1'b0;
    bcd2 = 8'($urandom);
    bcd4 = 16'($urandom);
    busy1 = wide ? busy4 : busy2;
    while (!(wide ? done4 : done2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = (wide ? done4 : done2) ? n : -1;
    bin = wide ? int'(bin4) : int'(bin2);
    e = wide ? err4 : err2;
    @(negedge clk);
    done_after = wide ? done4 : done2;
    bin_hold = wide ? int'(bin4) : int'(bin2);
  endtask

  task automatic test_reset;
    clr = 1'b0;
    start2 = 1'b0; start4 = 1'b0; bcd2 = '0; bcd4 = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy2, done2, err2, bin2} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset2: got busy=%b done=%b err=%b bin=%0d, want all 0", busy2, done2, err2, bin2);
    end
    n_cmp++;
    if ({busy4, done4, err4, bin4} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset4: got busy=%b done=%b err=%b bin=%0d, want all 0", busy4, done4, err4, bin4);
    end
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [7:0] vec [4] = '{8'h42, 8'h99, 8'h00, 8'h10};
    int lat, bin, bh, exp_v;
    bit e, b1, da, exp_e;
    for (int i = 0; i < 4; i++) begin
      ref_model({8'h0, vec[i]}, 2, exp_v, exp_e);
      conv(1'b0, {8'h0, vec[i]}, lat, bin, e, b1, da, bh);
      n_cmp++;
      if (lat !== 8) begin n_bad++; $display("FAIL vec_lat %h: got %0d, want 8", vec[i], lat); end
      n_cmp++;
      if (b1 !== 1'b1) begin n_bad++; $display("FAIL vec_busy %h: got %b, want 1", vec[i], b1); end
      n_cmp++;
      if (bin !== exp_v || e !== exp_e) begin
        n_bad++; $display("FAIL vec_val %h: got %0d err=%b, want %0d err=%b", vec[i], bin, e, exp_v, exp_e);
      end
      n_cmp++;
      if (da !== 1'b0 || bh !== exp_v) begin
        n_bad++; $display("FAIL vec_hold %h: got done=%b bin=%0d, want done=0 bin=%0d", vec[i], da, bh, exp_v);
      end
    end
  endtask

  task automatic test_invalid;
    int lat, bin, bh;
    bit e, b1, da;
    conv(1'b0, 16'h003A, lat, bin, e, b1, da, bh);
    n_cmp++;
    if (lat !== 1 || e !== 1'b1 || bin !== 0 || da !== 1'b0) begin
      n_bad++; $display("FAIL invalid_3A: got lat=%0d err=%b bin=%0d done_after=%b, want 1 1 0 0", lat, e, bin, da);
    end
    conv(1'b0, 16'h0007, lat, bin, e, b1, da, bh);
    n_cmp++;
    if (lat !== 8 || e !== 1'b0 || bin !== 7) begin
      n_bad++; $display("FAIL after_invalid_07: got lat=%0d err=%b bin=%0d, want 8 0 7", lat, e, bin);
    end
  endtask

  task automatic test_ignore_start;
    int ndone, first_lat, first_bin;
    ndone = 0; first_lat = -1; first_bin = -1;
    start2 = 1'b1; bcd2 = 8'h42;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start2 = (n == 3);
      bcd2 = (n == 3) ? 8'h55 : 8'($urandom);
      if (done2) begin
        ndone++;
        if (first_lat < 0) begin first_lat = n; first_bin = int'(bin2); end
      end
    end
    start2 = 1'b0;
    n_cmp++;
    if (ndone !== 1 || first_lat !== 8 || first_bin !== 42) begin
      n_bad++; $display("FAIL ignore_start: got dones=%0d lat=%0d bin=%0d, want 1 8 42", ndone, first_lat, first_bin);
    end
  endtask

  task automatic test_abort;
    int ndone, lat, bin, bh;
    bit e, b1, da;
    start2 = 1'b1; bcd2 = 8'h88;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if (busy2 !== 1'b0 || bin2 !== 7'd0 || done2 !== 1'b0) begin
      n_bad++; $display("FAIL abort_now: got busy=%b bin=%0d done=%b, want 0 0 0", busy2, bin2, done2);
    end
    @(negedge clk);
    clr = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done2) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d dones, want 0", ndone); end
    conv(1'b0, 16'h0088, lat, bin, e, b1, da, bh);
    n_cmp++;
    if (lat !== 8 || bin !== 88 || e !== 1'b0) begin
      n_bad++; $display("FAIL abort_retry: got lat=%0d bin=%0d err=%b, want 8 88 0", lat, bin, e);
    end
  endtask

  task automatic test_back_to_back;
    int t [$];
    int v [$];
    start2 = 1'b1; bcd2 = 8'h42;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done2) begin
        t.push_back(n);
        v.push_back(int'(bin2));
        if (t.size() == 1) bcd2 = 8'h17;
        else start2 = 1'b0;
      end
    end
    start2 = 1'b0;
    n_cmp++;
    if (t.size() != 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d dones, want 2", t.size());
    end else if (t[0] != 8 || t[1] != 17 || v[0] != 42 || v[1] != 17) begin
      n_bad++; $display("FAIL b2b_vals: got t=%0d,%0d bin=%0d,%0d, want 8,17 42,17", t[0], t[1], v[0], v[1]);
    end
  endtask

  task automatic test_random;
    logic [15:0] b;
    int lat, bin, bh, exp_v, exp_lat;
    bit e, b1, da, exp_e;
    for (int i = 0; i < 40; i++) begin
      bit wide;
      wide = (i >= 30);
      if ($urandom_range(0, 9) < 7) begin
        b = '0;
        for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
      end else begin
        b = 16'($urandom);
      end
      if (!wide) b[15:8] = 8'h0;
      ref_model(b, wide ? 4 : 2, exp_v, exp_e);
      exp_lat = exp_e ? 1 : (wide ? 15 : 8);
      conv(wide, b, lat, bin, e, b1, da, bh);
      n_cmp++;
      if (lat !== exp_lat || bin !== exp_v || e !== exp_e || da !== 1'b0) begin
        n_bad++;
        $display("FAIL random %h nd=%0d: got lat=%0d bin=%0d err=%b da=%b, want %0d %0d %b 0",
                 b, wide ? 4 : 2, lat, bin, e, da, exp_lat, exp_v, exp_e);
      end
    end
  endtask

  task automatic test_ndig4;
    int lat, bin, bh;
    bit e, b1, da;
    conv(1'b1, 16'h9999, lat, bin, e, b1, da, bh);
    n_cmp++;
    if (lat !== 15 || bin !== 9999 || e !== 1'b0 || bh !== 9999) begin
      n_bad++; $display("FAIL ndig4_9999: got lat=%0d bin=%0d err=%b hold=%0d, want 15 9999 0 9999", lat, bin, e, bh);
    end
    conv(1'b1, 16'h0001, lat, bin, e, b1, da, bh);
    n_cmp++;
    if (lat !== 15 || bin !== 1 || e !== 1'b0) begin
      n_bad++; $display("FAIL ndig4_0001: got lat=%0d bin=%0d err=%b, want 15 1 0", lat, bin, e);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_invalid();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    test_ndig4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential multi-digit BCD-to-binary decoder; the inverse of the BCD counter chain.
- Accepts NDIG packed BCD digits, for example the cascaded Q outputs of BCD_Counter stages, and produces the equivalent unsigned binary value.
- Uses reverse double-dabble: one right shift plus a per-digit correction each cycle.
- Start/busy/done handshake; feeds binary consumers such as compare logic and the LED/PWM blocks.

Parameters:
- NDIG, 2, number of BCD digits on bcd_in; legal range 1..4.
- BW, 7, binary result width; must satisfy 2^BW > 10^NDIG - 1. Use 4 for NDIG=1, 7 for 2, 10 for 3, 14 for 4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  asynchronous active-low reset; clr=0 forces the reset state immediately.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*NDIG  packed BCD digits; digit 0 is bits [3:0] (least significant).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; bin_out and err are valid from this cycle.
- bin_out  output  BW  binary result; holds its value until the next accepted start.
- err  output  1  set when any captured digit is greater than 9; holds until the next accepted start.

Behaviour:
- Reset (clr=0, async): state=IDLE, busy=0, done=0, err=0, bin_out=0, internal shift registers=0, iteration count=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - start=1 at a rising edge captures bcd_in into the digit register, clears the binary shift register and cnt, and clears err.
  - If any captured digit is greater than 9: err=1, bin_out=0, next state DONE (CONV is skipped).
  - Otherwise next state is CONV and busy=1.
- CONV, one iteration per cycle:
  - Shift the {digits, bin} register right by 1.
  - Then, for each digit that is 8 or greater, subtract 3. The correction applies to the shifted value within the same cycle.
  - cnt increments; when cnt==BW-1 is processed, next state is DONE.
  - Exactly BW CONV cycles per conversion.
- DONE:
  - done=1 and busy=0.
  - bin_out is loaded with the bin register on entry into DONE, so it is valid while done=1.
  - Next state is IDLE unconditionally.
- Latency:
  - Valid input: done is high in the cycle BW+1 edges after the edge that sampled start (NDIG=2 gives 8).
  - Invalid input: done is high 1 edge after the sampling edge.
- start while busy or in DONE is ignored; it is neither queued nor allowed to restart the conversion.
- start held high continuously: a new conversion is accepted on each IDLE edge, giving back-to-back conversions with one IDLE cycle between them.
- bcd_in may change after the capture edge without affecting the result.
- clr asserted mid-conversion aborts immediately to the reset state. No done pulse is produced, and bin_out returns to 0.
- Arithmetic is unsigned. Digit correction is 4-bit and cannot underflow, because it applies only to digits of 8 or more. The result is exact for every valid input because 10^NDIG - 1 < 2^BW.

Decomposition:
- Package bcd_pkg holds:
  - state encoding constants (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - BCD_MAX=4'd9;
  - DADJ_THRESH=4'd8;
  - DADJ_SUB=4'd3.
- Sub-module bcd_digit_adj is combinational, 4-bit in and 4-bit out: out = (in >= 8) ? in - 3 : in. It is instantiated NDIG times via generate.
- The top level holds the FSM, the counter and the registers.

Test Plan:
- Reset with clr=0, then release; start=1 with bcd_in=8'h42 for one cycle. Required: busy=1 next cycle; done pulses exactly 8 edges after the start edge; bin_out=7'd42; err=0.
- bcd_in=8'h99 gives bin_out=99. bcd_in=8'h00 gives bin_out=0. bcd_in=8'h10 gives bin_out=10. Each has done for exactly one cycle, and bin_out holds afterwards.
- bcd_in=8'h3A (invalid low digit): done 1 edge after start; err=1; bin_out=0. A following valid start with 8'h07 clears err and yields bin_out=7.
- Pulse start again with 8'h55 at cycle 3 of an 8'h42 conversion. Required: ignored, result remains 42, and no second done pulse.
- Drive clr=0 at cycle 4 of an 8'h88 conversion. Required: immediately busy=0, bin_out=0, no done pulse; after release, a start with 8'h88 yields 88.
- NDIG=4, BW=14: bcd_in=16'h9999 gives bin_out=9999 with done at edge 15; 16'h0001 gives bin_out=1.
